pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Parametrised successor to the fixed-field stage registers.
- Generic pipeline stage register carrying PC, instruction and a DATA_W-bit payload.
- Adds valid/ready handshake backed by a 2-entry skid buffer, so back-pressure never forms a combinational ready path.
- Sits between any two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and replaces the per-stage enable/flush registers.

Parameters:
DATA_W, 96, payload width (e.g. RD1, RD2, imm32 concatenated)
PC_W, 32, program-counter width
INSTR_W, 32, instruction width
CNT_W, 16, width of performance counters (optional feature only)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept; registered
in_pc  in  PC_W  upstream PC
in_instr  in  INSTR_W  upstream instruction
in_data  in  DATA_W  upstream payload
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts
out_pc  out  PC_W  held PC
out_instr  out  INSTR_W  held instruction
out_data  out  DATA_W  held payload
bubble_cnt  out  CNT_W  cycles with out_ready=1 and out_valid=0
flush_cnt  out  CNT_W  flushes that killed at least one valid entry

Behaviour:
- Transfer rules: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
- Storage: main register M drives the out_* ports; skid register S holds an overflow entry.
- States: EMPTY (M and S invalid), ONE (M valid), TWO (M and S valid).
- Transitions:
  - EMPTY: in_xfer -> ONE, with M loaded from in_*.
  - ONE: in_xfer & !out_xfer -> TWO, with S loaded.
  - ONE: in_xfer & out_xfer -> ONE, with M reloaded.
  - ONE: !in_xfer & out_xfer -> EMPTY.
  - TWO: out_xfer -> ONE, with M <= S. in_ready is 0 in TWO, so no input is taken.
- Outputs from state:
  - in_ready = 1 in EMPTY/ONE, 0 in TWO; it is a flop output.
  - out_valid = 1 in ONE/TWO.
- Latency: 1 cycle from in_xfer to out_valid when EMPTY. Throughput is 1 entry/cycle when out_ready stays high.
- Ordering: entries leave strictly FIFO; none dropped or duplicated.
- Invalid outputs: while out_valid=0, out_pc/out_instr/out_data read 0, so out_instr=0 acts as a nop for the DASM trace.
- Stability: while out_valid=1 and out_ready=0, out_* are held stable.
- Flush:
  - Next state is EMPTY, and M and S are zeroed.
  - Any same-cycle in_xfer is discarded; flush has priority over all transfers.
  - in_ready is 1 in the following cycle.
- Reset: asynchronous assert forces EMPTY, M=S=0, in_ready=0, out_valid=0, counters=0. in_ready goes to 1 on the first clk edge after reset deasserts.
- Reset mid-transfer: any held entries are lost. No partial update is allowed.
- Counters saturate at all-ones and never wrap.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: bubble_cnt and flush_cnt are live as described.
- Undefined: counter logic is not compiled, and both ports are tied to 0.
- Handshake behaviour is identical either way.

Decomposition:
- Package pipe_pkg:
  - state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2;
  - NOP_INSTR=32'h0000_0000.
- Sub-module sat_counter (parameter W; ports clk, reset, clr, inc, cnt), instantiated twice under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset low at t=0, release at cycle 2 -> out_valid=0, out_* =0 throughout; in_ready=1 from cycle 3.
- Streaming: in_valid=1, out_ready=1, PCs 0x3000, 0x3004, 0x3008 -> out_pc emits the same sequence one cycle later; in_ready stays 1.
- Back-pressure:
  - Stimulus: out_ready=0 while sending 0x3000, 0x3004, 0x3008.
  - Response: in_ready drops after the second accept; 0x3008 is held upstream.
  - Release: raising out_ready yields 0x3000, 0x3004, 0x3008 in order, no loss.
- Flush in state TWO with a simultaneous in_valid=1 (pc 0x300C) -> next cycle state EMPTY, out_valid=0, out_instr=0; 0x300C is never emitted; flush_cnt=1 (PERF_EN).
- Async reset asserted mid-cycle in ONE -> out_valid falls immediately, without waiting for clk.
- PERF_EN with CNT_W=4: 20 cycles of out_ready=1 and no input -> bubble_cnt saturates at 4'hF. Without the macro, bubble_cnt stays 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: state encoding and
// the instruction word presented while the stage holds nothing.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register (PC, instruction, payload) with a 2-entry skid
// buffer. Performance counters are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 96,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [1:0]         dbg_state
);

  localparam int ENT_W = PC_W + INSTR_W + DATA_W;
  localparam logic [ENT_W-1:0] NOP_ENT = {{PC_W{1'b0}}, INSTR_W'(NOP_INSTR), {DATA_W{1'b0}}};

  state_e           state_q, state_d;
  logic [ENT_W-1:0] m_q, m_d;
  logic [ENT_W-1:0] s_q, s_d;
  logic             in_ready_q, in_ready_d;
  logic             in_xfer, out_xfer;
  logic [ENT_W-1:0] in_ent;

  // Handshake: an entry moves on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and in_ready is a flop so no comb path backs up.
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;
  assign in_ent    = {in_pc, in_instr, in_data};
  assign out_valid = (state_q != ST_EMPTY);

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = ST_EMPTY;
      m_d     = NOP_ENT;
      s_d     = NOP_ENT;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_ONE;
            m_d     = in_ent;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            m_d = in_ent;
          end else if (in_xfer) begin
            state_d = ST_TWO;
            s_d     = in_ent;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
            m_d     = NOP_ENT;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            state_d = ST_ONE;
            m_d     = s_q;
            s_d     = NOP_ENT;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          m_d     = NOP_ENT;
          s_d     = NOP_ENT;
        end
      endcase
    end
    // Ready for next cycle is known from next state, so it can be registered.
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      m_q        <= NOP_ENT;
      s_q        <= NOP_ENT;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready                      = in_ready_q;
  assign {out_pc, out_instr, out_data} = m_q;
  assign dbg_state                     = state_q;

`ifdef PIPE_STAGE_PERF_EN
  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (out_ready & ~out_valid),
    .cnt   (bubble_cnt)
  );

  // Only flushes that actually discard a held entry are counted.
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (flush & out_valid),
    .cnt   (flush_cnt)
  );
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid against a queue-based FIFO model
// (capacity 2, registered ready), with directed scenarios and random traffic.
module tb_pipe_stage_skid;

  localparam int DATA_W  = 96;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 4;
  localparam int ENT_W   = PC_W + INSTR_W + DATA_W;

  logic               clk;
  logic               reset;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic [DATA_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [DATA_W-1:0]  out_data;
  logic [CNT_W-1:0]   bubble_cnt;
  logic [CNT_W-1:0]   flush_cnt;
  logic [1:0]         dbg_state;

  pipe_stage_skid #(
    .DATA_W(DATA_W), .PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_data(out_data),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model: the stage is a 2-deep FIFO whose ready is decided a cycle early
  logic [ENT_W-1:0] exp_q[$];
  logic             m_ready;
  logic [CNT_W-1:0] m_bubble;
  logic [CNT_W-1:0] m_flush;
  logic             last_acc;

  function automatic logic [ENT_W-1:0] mk_ent(input logic [31:0] pc);
    return {pc, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [ENT_W-1:0] exp_head();
    return (exp_q.size() != 0) ? exp_q[0] : '0;
  endfunction

  function automatic logic [CNT_W-1:0] exp_bubble();
`ifdef PIPE_STAGE_PERF_EN
    return m_bubble;
`else
    return '0;
`endif
  endfunction

  function automatic logic [CNT_W-1:0] exp_flush();
`ifdef PIPE_STAGE_PERF_EN
    return m_flush;
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ready  = 1'b0;
    m_bubble = '0;
    m_flush  = '0;
  endtask

  // driver: apply one cycle of inputs, advance the model, return at the negedge
  task automatic drive_cycle(input logic v, input logic [ENT_W-1:0] ent,
                             input logic ordy, input logic fl);
    in_valid  = v;
    {in_pc, in_instr, in_data} = ent;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    last_acc = v && m_ready && !fl;
    if (ordy && exp_q.size() == 0 && m_bubble != {CNT_W{1'b1}}) m_bubble++;
    if (fl && exp_q.size() != 0 && m_flush != {CNT_W{1'b1}}) m_flush++;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (ordy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (v && m_ready) exp_q.push_back(ent);
    end
    m_ready = (exp_q.size() < 2);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/0", out_valid, in_ready);
    end
    vectors++;
    if ({out_pc, out_instr, out_data} !== '0 || bubble_cnt !== '0 || flush_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_data: pc=%h instr=%h bub=%h fl=%h want all 0",
               out_pc, out_instr, bubble_cnt, flush_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: in_ready=%b want 0 before first edge", in_ready);
    end
    @(posedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_instr !== '0) begin
      miscompares++;
      $display("FAIL reset_ready: in_ready=%b out_valid=%b instr=%h want 1/0/0",
               in_ready, out_valid, out_instr);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [3];
    pcs[0] = 32'h3000; pcs[1] = 32'h3004; pcs[2] = 32'h3008;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, mk_ent(pcs[i]), 1'b1, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== pcs[i] || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_%0d: valid=%b pc=%h rdy=%b want 1/%h/1",
                 i, out_valid, out_pc, in_ready, pcs[i]);
      end
      vectors++;
      if ({out_pc, out_instr, out_data} !== exp_head()) begin
        miscompares++;
        $display("FAIL stream_ent_%0d: got %h want %h", i,
                 {out_pc, out_instr, out_data}, exp_head());
      end
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || out_instr !== '0) begin
      miscompares++;
      $display("FAIL stream_drain: valid=%b instr=%h want 0/0", out_valid, out_instr);
    end
  endtask

  task automatic test_back_pressure();
    logic [ENT_W-1:0] ents [3];
    logic [31:0]      got[$];
    int               idx;
    ents[0] = mk_ent(32'h3000); ents[1] = mk_ent(32'h3004); ents[2] = mk_ent(32'h3008);
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      drive_cycle(1'b1, ents[idx], 1'b0, 1'b0);
      if (last_acc) idx++;
    end
    vectors++;
    if (in_ready !== 1'b0 || idx != 2 || dbg_state !== 2'd2) begin
      miscompares++;
      $display("FAIL bp_stall: in_ready=%b accepted=%0d state=%0d want 0/2/2",
               in_ready, idx, dbg_state);
    end
    vectors++;
    if (out_pc !== 32'h3000) begin
      miscompares++;
      $display("FAIL bp_hold: out_pc=%h want 00003000", out_pc);
    end
    for (int c = 0; c < 12 && got.size() < 3; c++) begin
      if (out_valid) got.push_back(out_pc);
      drive_cycle(idx < 3, ents[(idx < 3) ? idx : 2], 1'b1, 1'b0);
      if (last_acc) idx++;
    end
    vectors++;
    if (got.size() != 3) begin
      miscompares++;
      $display("FAIL bp_count: emitted=%0d want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (got[i] !== ents[i][ENT_W-1 -: PC_W]) begin
          miscompares++;
          $display("FAIL bp_order_%0d: pc=%h want %h", i, got[i], ents[i][ENT_W-1 -: PC_W]);
        end
      end
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, mk_ent(32'h3000), 1'b0, 1'b0);
    drive_cycle(1'b1, mk_ent(32'h3004), 1'b0, 1'b0);
    vectors++;
    if (dbg_state !== 2'd2 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_fill: state=%0d in_ready=%b want 2/0", dbg_state, in_ready);
    end
    drive_cycle(1'b1, mk_ent(32'h300C), 1'b0, 1'b1);
    vectors++;
    if (dbg_state !== 2'd0 || out_valid !== 1'b0 || out_instr !== '0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_kill: state=%0d valid=%b instr=%h rdy=%b want 0/0/0/1",
               dbg_state, out_valid, out_instr, in_ready);
    end
    vectors++;
    if (flush_cnt !== exp_flush()) begin
      miscompares++;
      $display("FAIL flush_cnt: got %0d want %0d", flush_cnt, exp_flush());
    end
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      vectors++;
      if (out_valid !== 1'b0 || out_pc === 32'h300C) begin
        miscompares++;
        $display("FAIL flush_leak_%0d: valid=%b pc=%h want 0 and never 300c",
                 c, out_valid, out_pc);
      end
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b1, mk_ent(32'h3010), 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 32'h3010) begin
      miscompares++;
      $display("FAIL areset_fill: valid=%b pc=%h want 1/3010", out_valid, out_pc);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_pc !== '0) begin
      miscompares++;
      $display("FAIL areset_async: valid=%b rdy=%b pc=%h want 0/0/0",
               out_valid, in_ready, out_pc);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || bubble_cnt !== '0 || flush_cnt !== '0) begin
      miscompares++;
      $display("FAIL areset_after: rdy=%b bub=%0d fl=%0d want 1/0/0",
               in_ready, bubble_cnt, flush_cnt);
    end
  endtask

  task automatic test_bubble_sat();
    logic [CNT_W-1:0] want;
`ifdef PIPE_STAGE_PERF_EN
    want = 4'hF;
`else
    want = 4'h0;
`endif
    for (int c = 0; c < 20; c++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (bubble_cnt !== want || bubble_cnt !== exp_bubble()) begin
      miscompares++;
      $display("FAIL bubble_sat: got %h want %h", bubble_cnt, want);
    end
  endtask

  task automatic test_random();
    logic v, ordy, fl;
    for (int c = 0; c < 400; c++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 24) == 0);
      drive_cycle(v, mk_ent($urandom), ordy, fl);
      vectors++;
      if (out_valid !== (exp_q.size() != 0) || in_ready !== m_ready ||
          {out_pc, out_instr, out_data} !== exp_head() ||
          dbg_state !== 2'(exp_q.size())) begin
        miscompares++;
        $display("FAIL rand_%0d: valid=%b rdy=%b pc=%h state=%0d want %b/%b/%h/%0d", c,
                 out_valid, in_ready, out_pc, dbg_state, exp_q.size() != 0, m_ready,
                 exp_head() >> (INSTR_W + DATA_W), exp_q.size());
      end
      vectors++;
      if (bubble_cnt !== exp_bubble() || flush_cnt !== exp_flush()) begin
        miscompares++;
        $display("FAIL rand_cnt_%0d: bub=%0d fl=%0d want %0d/%0d", c,
                 bubble_cnt, flush_cnt, exp_bubble(), exp_flush());
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    in_data   = '0;
    model_reset();
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_async_reset();
    test_bubble_sat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
